// File: rtl/halut_pkg.sv
// halut_pkg: shared constants, fp16 field widths and FSM state type for the halut tree encoder.
package halut_pkg;
    localparam int TREE_DEPTH = 4;
    localparam int DATA_WIDTH = 16;
    localparam int FP_SIGN_W  = 1;
    localparam int FP_EXP_W   = 5;
    localparam int FP_MAN_W   = 10;
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;
endpackage

// File: rtl/fp_16_comparision.sv
// fp_16_comparision: combinational strict a > b on fp16 bit patterns (sign, then exponent, then mantissa).
module fp_16_comparision
    import halut_pkg::*;
(
    input  logic [DATA_WIDTH-1:0] a_i,
    input  logic [DATA_WIDTH-1:0] b_i,
    output logic                  gt_o
);
    localparam int MagW = FP_EXP_W + FP_MAN_W;
    logic                a_s, b_s;
    logic [MagW-1:0]     a_m, b_m;
    assign a_s = a_i[MagW +: FP_SIGN_W];
    assign b_s = b_i[MagW +: FP_SIGN_W];
    assign a_m = a_i[MagW-1:0];
    assign b_m = b_i[MagW-1:0];
    // Exponent sits above mantissa, so one magnitude compare orders both; negatives invert it.
    always_comb gt_o = (a_s != b_s) ? ~a_s : (a_s ? (a_m < b_m) : (a_m > b_m));
endmodule

// File: rtl/halut_threshold_rf.sv
// halut_threshold_rf: NumNodes x DataWidth threshold register file, sync write, async read, sync reset.
module halut_threshold_rf
    import halut_pkg::*;
#(
    parameter int AddrWidth = TREE_DEPTH,
    parameter int DataWidth = DATA_WIDTH
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 we_i,
    input  logic [AddrWidth-1:0] waddr_i,
    input  logic [DataWidth-1:0] wdata_i,
    input  logic [AddrWidth-1:0] raddr_i,
    output logic [DataWidth-1:0] rdata_o
);
    localparam int NumNodes = 2**AddrWidth - 1;
    logic [DataWidth-1:0] mem_q [NumNodes];
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < NumNodes; i++) mem_q[i] <= '0;
        end else if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end
    assign rdata_o = (raddr_i < AddrWidth'(NumNodes)) ? mem_q[raddr_i] : '0;
endmodule

// File: rtl/halut_tree_encoder.sv
// halut_tree_encoder: walks a balanced fp16 threshold tree one level per cycle, emitting the leaf index.
module halut_tree_encoder
    import halut_pkg::*;
#(
    parameter int TreeDepth = TREE_DEPTH,
    parameter int DataWidth = DATA_WIDTH
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    input  logic                           in_valid_i,
    output logic                           in_ready_o,
    input  logic [TreeDepth*DataWidth-1:0] in_feat_i,
    output logic                           out_valid_o,
    input  logic                           out_ready_i,
    output logic [TreeDepth-1:0]           out_idx_o,
    input  logic                           cfg_we_i,
    input  logic [TreeDepth-1:0]           cfg_addr_i,
    input  logic [DataWidth-1:0]           cfg_data_i,
    output logic                           cfg_err_o,
    output logic                           busy_o
);
    localparam int NumNodes = 2**TreeDepth - 1;
    localparam int LvlW     = $clog2(TreeDepth);
    state_e                         state_q, state_d;
    logic [LvlW-1:0]                level_q, level_d;
    logic [TreeDepth-1:0]           idx_q, idx_d;
    logic [TreeDepth*DataWidth-1:0] feat_q, feat_d;
    logic                           cfg_err_q, cfg_err_d;
    logic                           cfg_ok, cmp;
    logic [TreeDepth-1:0]           node;
    logic [DataWidth-1:0]           thr, feat;
    // Level l nodes start at 2**l - 1; idx holds the decisions taken so far.
    assign node = (TreeDepth'(1) << level_q) - TreeDepth'(1) + idx_q;
    assign feat = feat_q[level_q*DataWidth +: DataWidth];
    assign cfg_ok    = cfg_we_i & (state_q != RUN) & (cfg_addr_i < TreeDepth'(NumNodes));
    assign cfg_err_d = cfg_we_i & ~cfg_ok;
    halut_threshold_rf #(.AddrWidth(TreeDepth), .DataWidth(DataWidth)) u_rf (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .we_i   (cfg_ok),
        .waddr_i(cfg_addr_i),
        .wdata_i(cfg_data_i),
        .raddr_i(node),
        .rdata_o(thr)
    );
    fp_16_comparision u_cmp (.a_i(feat), .b_i(thr), .gt_o(cmp));
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            level_q   <= '0;
            idx_q     <= '0;
            feat_q    <= '0;
            cfg_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            level_q   <= level_d;
            idx_q     <= idx_d;
            feat_q    <= feat_d;
            cfg_err_q <= cfg_err_d;
        end
    end
    always_comb begin
        state_d = state_q;
        level_d = level_q;
        idx_d   = idx_q;
        feat_d  = feat_q;
        case (state_q)
            IDLE: if (in_valid_i) begin
                state_d = RUN;
                level_d = '0;
                idx_d   = '0;
                feat_d  = in_feat_i;
            end
            RUN: begin
                idx_d   = {idx_q[TreeDepth-2:0], cmp};
                level_d = level_q + LvlW'(1);
                state_d = (level_q == LvlW'(TreeDepth-1)) ? DONE : RUN;
            end
            DONE:    state_d = out_ready_i ? IDLE : DONE;
            default: state_d = IDLE;
        endcase
    end
    assign in_ready_o  = state_q == IDLE;
    assign out_valid_o = state_q == DONE;
    assign busy_o      = state_q == RUN;
    assign out_idx_o   = idx_q;
    assign cfg_err_o   = cfg_err_q;
endmodule

// File: tb/tb_halut_tree_encoder.sv
// tb_halut_tree_encoder: directed vectors checked against a heap-walk model of the tree encoder.
module tb_halut_tree_encoder;
    localparam int TD = 4;
    localparam int NN = 15;
    logic          clk = 0, rst = 1, in_valid = 0, out_ready = 1, cfg_we = 0;
    logic [63:0]   in_feat = '0;
    logic [3:0]    cfg_addr = '0;
    logic [15:0]   cfg_data = '0;
    logic          in_ready, out_valid, cfg_err, busy;
    logic [3:0]    out_idx;
    int            checks = 0, errors = 0;
    int            phase = 0;
    logic [15:0]   thr_m [NN];
    logic [3:0]    exp_idx = '0;
    logic          exp_err = 0;
    bit            live = 0;

    halut_tree_encoder dut (
        .clk_i(clk), .rst_i(rst), .in_valid_i(in_valid), .in_ready_o(in_ready),
        .in_feat_i(in_feat), .out_valid_o(out_valid), .out_ready_i(out_ready),
        .out_idx_o(out_idx), .cfg_we_i(cfg_we), .cfg_addr_i(cfg_addr),
        .cfg_data_i(cfg_data), .cfg_err_o(cfg_err), .busy_o(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Total-order key: positives above negatives, negatives reversed by magnitude.
    function automatic logic [15:0] key(input logic [15:0] x);
        return x[15] ? ~x : (x | 16'h8000);
    endfunction

    // Heap walk: children of node n are 2n+1 (not greater) and 2n+2 (greater).
    function automatic logic [3:0] walk(input logic [63:0] f);
        int n = 0;
        for (int l = 0; l < TD; l++) n = 2 * n + 1 + ((key(f[l*16 +: 16]) > key(thr_m[n])) ? 1 : 0);
        return 4'(n - NN);
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            phase = 0;
            exp_err = 0;
            for (int i = 0; i < NN; i++) thr_m[i] = '0;
            live = 1;
        end else begin
            exp_err = cfg_we && ((phase >= 1 && phase <= TD) || cfg_addr >= NN);
            if (cfg_we && !(phase >= 1 && phase <= TD) && cfg_addr < NN) thr_m[cfg_addr] = cfg_data;
            if (phase == 0) begin
                if (in_valid) begin
                    phase = 1;
                    exp_idx = walk(in_feat);
                end
            end else if (phase <= TD) phase++;
            else if (out_ready) phase = 0;
        end
    end

    always @(negedge clk) begin
        if (live) begin
            chk("out_valid", 16'(out_valid), 16'(phase == TD + 1));
            chk("in_ready", 16'(in_ready), 16'(phase == 0));
            chk("busy", 16'(busy), 16'(phase >= 1 && phase <= TD));
            chk("cfg_err", 16'(cfg_err), 16'(exp_err));
            if (phase == TD + 1) chk("model_idx", 16'(out_idx), 16'(exp_idx));
        end
    end

    task automatic cfg_wr(input logic [3:0] a, input logic [15:0] d);
        cfg_we = 1; cfg_addr = a; cfg_data = d;
        @(posedge clk); #1 cfg_we = 0;
    endtask

    task automatic issue(input logic [63:0] f);
        in_feat = f; in_valid = 1;
        @(posedge clk); #1 in_valid = 0;
    endtask

    task automatic wait_valid();
        int n = 0;
        while (!out_valid && n < 20) begin
            @(posedge clk); #1 n++;
        end
        chk("wait_out_valid", 16'(out_valid), 16'd1);
    endtask

    task automatic finish_req(input logic [3:0] lit);
        wait_valid();
        chk("lit_idx", 16'(out_idx), 16'(lit));
        @(posedge clk); #1;
    endtask

    task automatic req(input logic [63:0] f, input logic [3:0] lit);
        issue(f);
        finish_req(lit);
    endtask

    initial begin
        #100000 $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(posedge clk);
        #1 rst = 0;
        chk("rst_idx", 16'(out_idx), 16'h0);
        chk("rst_ready", 16'(in_ready), 16'h1);
        chk("rst_valid", 16'(out_valid), 16'h0);
        req({4{16'h3C00}}, 4'hF);
        req({4{16'hBC00}}, 4'h0);
        req({16'hBC00, 16'h3C00, 16'hBC00, 16'h3C00}, 4'hA);
        cfg_wr(4'd12, 16'h4000);
        req({16'h3C00, 16'h3C00, 16'hBC00, 16'h3C00}, 4'hA);
        cfg_wr(4'd12, 16'h3800);
        req({16'h3C00, 16'h3C00, 16'hBC00, 16'h3C00}, 4'hB);
        cfg_wr(4'd0, 16'hC000);
        req({48'h0, 16'hBC00}, 4'h8);
        cfg_wr(4'd0, 16'h3C00);
        req({48'h0, 16'h3C00}, 4'h0);
        cfg_wr(4'd0, 16'h8000);
        req({48'h0, 16'h0000}, 4'h8);
        // Backpressure: hold DONE, offer a competing request that must be refused.
        out_ready = 0;
        issue({4{16'h3C00}});
        wait_valid();
        in_feat = {4{16'hBC00}}; in_valid = 1;
        repeat (3) begin
            @(posedge clk); #1;
            chk("bp_idx", 16'(out_idx), 16'hF);
            chk("bp_ready", 16'(in_ready), 16'h0);
        end
        in_valid = 0; out_ready = 1;
        @(posedge clk); #1;
        chk("bp_release_ready", 16'(in_ready), 16'h1);
        req({4{16'hBC00}}, 4'h0);
        // Rejected writes: out-of-range address, then a write while running.
        cfg_wr(4'd15, 16'h1234);
        issue({16'hBC00, 16'h3C00, 16'hBC00, 16'hBC00});
        cfg_we = 1; cfg_addr = 4'd3; cfg_data = 16'h7C00;
        @(posedge clk); #1 cfg_we = 0;
        chk("run_wr_err", 16'(cfg_err), 16'h1);
        finish_req(4'h2);
        req({16'hBC00, 16'h3C00, 16'hBC00, 16'hBC00}, 4'h2);
        // Write coinciding with accept is seen by that traversal.
        in_feat = {4{16'h3C00}}; in_valid = 1;
        cfg_we = 1; cfg_addr = 4'd0; cfg_data = 16'h4000;
        @(posedge clk); #1 in_valid = 0; cfg_we = 0;
        finish_req(4'h7);
        // Reset while at level 2.
        issue({4{16'h3C00}});
        repeat (2) begin
            @(posedge clk); #1;
        end
        chk("mid_busy", 16'(busy), 16'h1);
        rst = 1;
        @(posedge clk); #1 rst = 0;
        chk("mid_rst_ready", 16'(in_ready), 16'h1);
        chk("mid_rst_valid", 16'(out_valid), 16'h0);
        chk("mid_rst_busy", 16'(busy), 16'h0);
        req({4{16'h3C00}}, 4'hF);
        req({16'h0000, 16'h0000, 16'h0000, 16'h8000}, 4'h0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/halut_tree_encoder.md
Name: halut_tree_encoder

Overview:
- Sequential decision-tree encoder for the halut datapath. Walks a balanced binary tree of fp16 thresholds and emits the leaf (prototype) index for one input.
- One fp_16_comparision instance is time-shared across levels, one tree level per clock cycle.
- Sits between the feature-select stage, which supplies one fp16 value per tree level, and the LUT read stage, which consumes the prototype index.

Parameters:
- TreeDepth, 4, number of tree levels; the output index is TreeDepth bits wide.
- DataWidth, 16, feature/threshold width; only 16 is supported, because it is fixed by the comparator.
- NumNodes, 2**TreeDepth-1, derived localparam: number of threshold registers.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  synchronous reset, active-high.
- in_valid_i  in  1  input request valid.
- in_ready_o  out  1  block can accept a request.
- in_feat_i  in  TreeDepth*DataWidth  per-level fp16 features; level l occupies bits [l*16 +: 16].
- out_valid_o  out  1  result valid.
- out_ready_i  in  1  downstream accepts the result.
- out_idx_o  out  TreeDepth  leaf index; the level-0 decision is the MSB.
- cfg_we_i  in  1  threshold write strobe.
- cfg_addr_i  in  TreeDepth  threshold node address.
- cfg_data_i  in  DataWidth  fp16 threshold value.
- cfg_err_o  out  1  one-cycle pulse when a write is rejected.
- busy_o  out  1  high while in RUN.

Behaviour:
- Clocking and reset:
  - Single clock, synchronous active-high reset. Reset takes priority over every other event.
  - Reset values: state IDLE; in_ready_o=1; out_valid_o=0; out_idx_o=0; cfg_err_o=0; busy_o=0; all thresholds 0x0000.
- FSM states: IDLE, RUN, DONE.
  - IDLE: in_ready_o=1. On in_valid_i&in_ready_o: latch in_feat_i, level<=0, idx<=0, go to RUN.
  - RUN: each cycle, node = (2**level - 1) + idx and cmp = fp_16_comparision(feat[level], thr[node]).
    - Update idx<={idx[TreeDepth-2:0], cmp} and level<=level+1.
    - When level==TreeDepth-1, go to DONE.
  - DONE: out_valid_o=1 and out_idx_o=idx, both held stable until out_ready_i. On out_valid_o&out_ready_i, go to IDLE.
- Handshake:
  - in_ready_o is low in RUN and DONE.
  - No same-cycle DONE->accept bypass; the earliest next accept is the cycle after the output handshake.
- Timing:
  - out_valid_o rises exactly TreeDepth cycles after the input handshake edge.
  - Minimum initiation interval is TreeDepth+2 cycles.
- Decision rule:
  - cmp=1 iff feature > threshold, strictly, with the comparator's semantics: sign first, then exponent, then mantissa, sign-corrected for negatives.
  - Equal operands give 0. +0 vs -0 gives 1.
  - NaN and Inf get no special handling; they are ordered by bit pattern as the comparator does.
  - Comparator operands are driven from registers only; the comparator output is not registered, and the decision is registered into idx.
- Configuration:
  - cfg_we_i with cfg_addr_i<NumNodes, while state!=RUN, writes the threshold at the next edge.
  - A write during RUN, or with cfg_addr_i>=NumNodes, is ignored and cfg_err_o pulses for 1 cycle.
  - A write in the same cycle as an input accept is allowed. The new value is visible to that traversal, because RUN starts next cycle.
- Reset mid-operation: rst_i in RUN or DONE aborts the traversal, drops out_valid_o the next cycle, and clears all thresholds.

Decomposition:
- halut_pkg holds:
  - the state enum (IDLE, RUN, DONE);
  - the TreeDepth default and the DataWidth=16 constant;
  - the fp16 field-width constants (1/5/10).
- Natural sub-module: halut_threshold_rf, a NumNodes x 16 register file with a synchronous write port, one asynchronous read port and synchronous reset.
- The FSM and the fp_16_comparision instance stay in the top module.

Test Plan:
- All thresholds 0x0000, features all 0x3C00 (+1.0) -> out_idx_o=4'hF, out_valid_o high 4 cycles after accept. Features all 0xBC00 (-1.0) -> 4'h0.
- Node addressing: thresholds 0, features {l0=0x3C00, l1=0xBC00, l2=0x3C00, l3=0xBC00} -> 4'hA, visiting nodes 0,2,5,12. Then write thr[12]=0x4000 and features l3=0x3C00 -> 4'hA (1.0 not > 2.0). Then write thr[12]=0x3800 -> 4'hB.
- Sign and equality corners, each checked on thr[0] with other levels forced 0:
  - x=0xBC00 vs thr 0xC000 -> MSB=1 (-1 > -2);
  - x=0x3C00 vs thr 0x3C00 -> MSB=0 (equal);
  - x=0x0000 vs thr 0x8000 -> MSB=1 (+0 vs -0).
- Backpressure: hold out_ready_i=0 for 3 cycles in DONE -> out_idx_o stable, in_ready_o=0, a new in_valid_i is not accepted. Release -> IDLE next cycle, next accept the cycle after.
- Config errors: a write to addr 15 with TreeDepth=4 -> cfg_err_o pulse, no register changes. A write to addr 3 during RUN -> cfg_err_o pulse, thr[3] unchanged, traversal result unaffected.
- Reset mid-RUN: assert rst_i at level 2 -> next cycle IDLE, in_ready_o=1, out_valid_o=0, all thresholds read back 0x0000. A following all-+1.0 request -> 4'hF.
